// File: rtl/reel_pkg.sv
// Shared definitions for the reel spin controller: symbol sizing and FSM state type.
package reel_pkg;

  localparam int SYM_W   = 4;
  localparam int NUM_SYM = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPIN,
    ST_DECEL,
    ST_SETTLE
  } reel_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick at the start of each video frame, aligned with the
// downstream sprite generator (fires when x steps from 0 to 1 on line 0).
module frame_tick_gen (
  input  logic        clk,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        tick
);

  logic [10:0] x_d1;

  always_ff @(posedge clk) begin
    x_d1 <= x;
  end

  assign tick = (x_d1 == 11'd0) && (x == 11'd1) && (y == 11'd0);

endmodule

// File: rtl/reel_spin_ctrl.sv
// Reel spin sequencer: full-speed spin, progressive deceleration onto a
// seed-chosen target symbol, settle hold, then a done pulse with the result.
module reel_spin_ctrl #(
  parameter int NUM_SYM       = reel_pkg::NUM_SYM,
  parameter int SPIN_FRAMES   = 90,
  parameter int FAST_DIV      = 2,
  parameter int MAX_DIV       = 8,
  parameter int SETTLE_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        start,
  input  logic        stop_req,
  output logic [4:0]  ctrl,
  output logic        busy,
  output logic        done,
  output logic [3:0]  result
);

  import reel_pkg::*;

  // All frame-count parameters must fit the 8-bit counters (<= 255).
  localparam logic [7:0]       SPIN_F   = 8'(SPIN_FRAMES);
  localparam logic [7:0]       FAST_D   = 8'(FAST_DIV);
  localparam logic [7:0]       MAX_D    = 8'(MAX_DIV);
  localparam logic [7:0]       SETTLE_F = 8'(SETTLE_FRAMES);
  localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(NUM_SYM - 1);

  function automatic logic [SYM_W-1:0] sym_inc(input logic [SYM_W-1:0] s);
    return (s >= LAST_SYM) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic                tick;
  reel_state_t         state, state_nx;
  logic [SYM_W-1:0]    sym_id, sym_nx;
  logic [SYM_W-1:0]    target, target_nx;
  logic [SYM_W-1:0]    seed, seed_nx;
  logic [SYM_W-1:0]    result_nx;
  logic [7:0]          period, period_nx;
  logic [7:0]          div_cnt, div_nx;
  logic [7:0]          frame_cnt, frame_nx;
  logic                done_nx;
  logic                busy_nx;

  frame_tick_gen u_tick (
    .clk  (clk),
    .x    (x),
    .y    (y),
    .tick (tick)
  );

  always_comb begin
    state_nx  = state;
    sym_nx    = sym_id;
    target_nx = target;
    period_nx = period;
    div_nx    = div_cnt;
    frame_nx  = frame_cnt;
    result_nx = result;
    done_nx   = 1'b0;
    seed_nx   = (seed >= LAST_SYM) ? '0 : seed + 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx  = ST_SPIN;
          target_nx = seed;
          frame_nx  = '0;
          div_nx    = '0;
          period_nx = FAST_D;
        end
      end

      ST_SPIN: begin
        if (tick) begin
          frame_nx = sat_inc(frame_cnt);
          if (sat_inc(div_cnt) >= FAST_D) begin
            sym_nx = sym_inc(sym_id);
            div_nx = '0;
          end else begin
            div_nx = sat_inc(div_cnt);
          end
        end
        // The expiring tick still belongs to SPIN; DECEL starts with clean counters.
        if (stop_req || (tick && (sat_inc(frame_cnt) >= SPIN_F))) begin
          state_nx = ST_DECEL;
          frame_nx = '0;
          div_nx   = '0;
        end
      end

      ST_DECEL: begin
        if (tick) begin
          frame_nx = sat_inc(frame_cnt);
          if (sat_inc(div_cnt) >= period) begin
            sym_nx    = sym_inc(sym_id);
            div_nx    = '0;
            period_nx = (period >= MAX_D) ? MAX_D : period + 8'd1;
            if ((period == MAX_D) && (sym_inc(sym_id) == target)) begin
              state_nx = ST_SETTLE;
              frame_nx = '0;
            end
          end else begin
            div_nx = sat_inc(div_cnt);
          end
        end
      end

      ST_SETTLE: begin
        if (tick) begin
          if (sat_inc(frame_cnt) >= SETTLE_F) begin
            state_nx  = ST_IDLE;
            frame_nx  = '0;
            done_nx   = 1'b1;
            result_nx = sym_id;
          end else begin
            frame_nx = sat_inc(frame_cnt);
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase

    // busy stays up through the done cycle so the pulse is always framed by it.
    busy_nx = (state_nx != ST_IDLE) || done_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      sym_id    <= '0;
      target    <= '0;
      seed      <= '0;
      period    <= FAST_D;
      div_cnt   <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_nx;
      sym_id    <= sym_nx;
      target    <= target_nx;
      seed      <= seed_nx;
      period    <= period_nx;
      div_cnt   <= div_nx;
      frame_cnt <= frame_nx;
      done      <= done_nx;
      busy      <= busy_nx;
      result    <= result_nx;
    end
  end

  assign ctrl = {1'b0, sym_id};

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Randomized bench for reel_spin_ctrl against a spin-schedule reference model.
module tb_reel_spin_ctrl;

  localparam int NS = 13;
  localparam int SF = 6;
  localparam int FD = 2;
  localparam int MD = 4;
  localparam int SE = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic        start = 1'b0;
  logic        stop_req = 1'b0;
  logic [4:0]  ctrl;
  logic        busy;
  logic        done;
  logic [3:0]  result;

  reel_spin_ctrl #(
    .NUM_SYM(NS), .SPIN_FRAMES(SF), .FAST_DIV(FD), .MAX_DIV(MD), .SETTLE_FRAMES(SE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .start(start), .stop_req(stop_req),
    .ctrl(ctrl), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int xr = 0, yr = 0, xprev = 0;
  bit active = 0;
  int nt = 0, ndone = 0, tgt = 0, seed_m = 0, spin_len = 0;
  int e_sym = 0, e_busy = 0, e_done = 0, e_res = 0;
  int sched [256];
  int plan_s = 99;
  bit plan_tick = 0, stop_sent = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected symbol after each frame tick of a spin; returns the tick index of done.
  function automatic int build(input int sym, input int target, input int len);
    int n;
    int period;
    int c;
    n = len;
    period = FD;
    c = 0;
    sched[0] = sym;
    for (int i = 1; i <= len; i++) begin
      if (i % FD == 0) sym = (sym + 1) % NS;
      sched[i] = sym;
    end
    while (n < 200) begin
      n++;
      c++;
      if (c == period) begin
        sym = (sym + 1) % NS;
        c = 0;
        if (period == MD && sym == target) begin
          sched[n] = sym;
          break;
        end
        period = (period + 1 > MD) ? MD : period + 1;
      end
      sched[n] = sym;
    end
    for (int i = 1; i <= SE; i++) sched[n + i] = sym;
    return n + SE;
  endfunction

  task automatic step(input bit st, input bit sp_in, input bit rn);
    bit tk;
    bit sp;
    xr = (xr + 1) % 4;
    if (xr == 0) yr = (yr + 1) % 2;
    tk = (xprev == 0) && (xr == 1) && (yr == 0);
    sp = sp_in;
    if (rn && active && !stop_sent) begin
      if (plan_tick && tk && (nt + 1 == plan_s)) begin
        sp = 1'b1;
        stop_sent = 1'b1;
      end else if (!plan_tick && !tk && (nt == plan_s)) begin
        sp = 1'b1;
        stop_sent = 1'b1;
      end
    end
    x = 11'(xr);
    y = 11'(yr);
    start = st;
    stop_req = sp;
    reset_n = rn;
    xprev = xr;

    if (!rn) begin
      active = 0; e_sym = 0; e_busy = 0; e_done = 0; e_res = 0; seed_m = 0;
    end else begin
      e_done = 0;
      if (!active) begin
        if (st) begin
          tgt = seed_m;
          spin_len = (plan_s < SF) ? plan_s : SF;
          ndone = build(e_sym, tgt, spin_len);
          nt = 0;
          active = 1;
          stop_sent = 0;
        end
      end else if (tk) begin
        nt++;
        e_sym = sched[nt];
        if (nt == ndone) begin
          e_done = 1;
          e_res = e_sym;
          active = 0;
        end
      end
      e_busy = (active || e_done) ? 1 : 0;
      seed_m = (seed_m + 1) % NS;
    end

    @(posedge clk);
    @(negedge clk);
    check("ctrl", int'(ctrl), e_sym);
    check("busy", int'(busy), e_busy);
    check("done", int'(done), e_done);
    check("result", int'(result), e_res);
    check("ctrl_range", int'(ctrl < 5'(NS)), 1);
    check("ctrl4", int'(ctrl[4]), 0);
  endtask

  task automatic idle_step();
    step(1'b0, $urandom_range(0, 7) == 0, 1'b1);
  endtask

  task automatic wait_seed(input int k);
    for (int i = 0; i < NS + 1 && seed_m != k; i++) idle_step();
  endtask

  task automatic run_spin(input bit with_stop, input int ps, input bit ptick, input int abort_at);
    int guard;
    guard = 0;
    plan_s = ps;
    plan_tick = ptick;
    stop_sent = 0;
    step(1'b1, with_stop, 1'b1);
    while (active && guard < 3000) begin
      guard++;
      if (abort_at != 0 && nt == abort_at) begin
        step(1'b0, 1'b0, 1'b0);
        break;
      end
      step($urandom_range(0, 15) == 0, (nt > spin_len) && ($urandom_range(0, 15) == 0), 1'b1);
    end
    check("spin_bounded", int'(guard < 3000), 1);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Basic spin landing on seed 5 from a reset reel.
    wait_seed(5);
    run_spin(1'b0, 99, 1'b0, 0);
    check("first_result", int'(result), 5);

    // Target 0 forces a 12 -> 0 wrap on the final lap.
    wait_seed(0);
    run_spin(1'b0, 99, 1'b0, 0);
    check("wrap_result", int'(result), 0);

    // Early stop after SPIN tick 2, then stop coinciding with SPIN expiry.
    run_spin(1'b0, 2, 1'b0, 0);
    run_spin(1'b0, SF, 1'b1, 0);

    // start and stop_req together in IDLE.
    repeat (4) idle_step();
    run_spin(1'b1, 99, 1'b0, 0);

    // Reset pulse mid-DECEL, quiet period, then a normal spin.
    run_spin(1'b0, 99, 1'b0, SF + 3);
    repeat (20) idle_step();
    run_spin(1'b0, 99, 1'b0, 0);
    check("post_reset_result", int'(result), tgt);

    for (int s = 0; s < 10; s++) begin
      int gap;
      int ps;
      gap = $urandom_range(0, 12);
      for (int g = 0; g < gap; g++) idle_step();
      ps = ($urandom_range(0, 3) == 0) ? 99 : int'($urandom_range(1, SF + 1));
      run_spin($urandom_range(0, 1) == 1, ps, $urandom_range(0, 1) == 1, 0);
    end
    repeat (10) idle_step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reel_spin_ctrl.md
REEL_SPIN_CTRL -- requirements
Module: reel_spin_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_SYM, default 13, meaning the number of symbol frames on the strip (ids 0..NUM_SYM-1).
REQ-002 The module SHALL have parameter SPIN_FRAMES, default 90, meaning the frame ticks spent at full speed before decelerating.
REQ-003 The module SHALL have parameter FAST_DIV, default 2, meaning the frame ticks per symbol advance at full speed.
REQ-004 The module SHALL have parameter MAX_DIV, default 8, meaning the frame ticks per symbol advance at slowest speed.
REQ-005 The module SHALL have parameter SETTLE_FRAMES, default 30, meaning the frame ticks held on the landed symbol before done.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The module SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The module SHALL have port x, input, 11 bits: the current pixel x-coordinate.
REQ-009 The module SHALL have port y, input, 11 bits: the current pixel y-coordinate.
REQ-010 The module SHALL have port start, input, 1 bit: a one-cycle spin request.
REQ-011 The module SHALL have port stop_req, input, 1 bit: a one-cycle player request to begin decelerating early.
REQ-012 The module SHALL have port ctrl, output, 5 bits: the sprite control for the downstream reel sprite generator, {auto=0, sym_id[3:0]}.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The module SHALL have port done, output, 1 bit: a one-cycle pulse when the reel has settled.
REQ-015 The module SHALL have port result, output, 4 bits: the landed symbol id, held until the next done.

Function
REQ-016 The frame tick SHALL be generated as x_d1==0 && x==1 && y==0, where x_d1 is x registered one cycle, matching the downstream sprite timing.
REQ-017 A free-running 4-bit seed counter SHALL increment every clock and wrap from NUM_SYM-1 to 0.
REQ-018 The FSM SHALL have the states IDLE, SPIN, DECEL and SETTLE.
REQ-019 In IDLE, start SHALL move the FSM to SPIN, latch target=seed, clear the frame and period counters, and set period=FAST_DIV.
REQ-020 In SPIN, sym_id SHALL advance once every FAST_DIV frame ticks.
REQ-021 In SPIN, the FSM SHALL move to DECEL after SPIN_FRAMES frame ticks, or on the cycle after stop_req, whichever occurs first.
REQ-022 In DECEL, sym_id SHALL advance every period frame ticks, and period SHALL become min(period+1, MAX_DIV) at each advance.
REQ-023 In DECEL, the FSM SHALL move to SETTLE on an advance where the pre-advance period equals MAX_DIV and the new sym_id equals target.
REQ-024 In SETTLE, after SETTLE_FRAMES frame ticks the module SHALL pulse done for one cycle, load result=sym_id in the same cycle, and move to IDLE.
REQ-025 Every sym_id advance SHALL wrap from NUM_SYM-1 to 0.
REQ-026 sym_id SHALL never hold a value of NUM_SYM or greater.
REQ-027 All counters SHALL saturate or clear explicitly and SHALL have no unintended wrap.
REQ-028 The frame counter SHALL be 8 bits wide, and parameters SHALL be limited to 255 or less.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 stop_req SHALL be ignored outside SPIN.
REQ-031 If start and stop_req are both high in IDLE, start SHALL be accepted and stop_req discarded.
REQ-032 A frame tick coinciding with a state transition SHALL not be counted in the new state.
REQ-033 stop_req and an expiring SPIN_FRAMES in the same cycle SHALL produce a single DECEL entry.
REQ-034 ctrl, busy, done and result SHALL be registered outputs, with a latency of one clock from the causing event.
REQ-035 ctrl[4] SHALL always be 0.

Reset
REQ-036 reset_n low at a clock edge SHALL force state=IDLE, sym_id=0, result=0, done=0, busy=0, all counters=0, seed=0, period=FAST_DIV and target=0.
REQ-037 Reset asserted mid-spin SHALL abort the spin without pulsing done.

Structure
REQ-038 A shared package reel_pkg SHALL hold the state enum typedef, the symbol-id width constant (4), and NUM_SYM.
REQ-039 Frame-tick generation SHALL be a sub-module frame_tick_gen (clk, x, y, tick), reusable by other reels.
REQ-040 The FSM, the counters and the output registers SHALL stay in reel_spin_ctrl.

Verification (testbench with SPIN_FRAMES=6, FAST_DIV=2, MAX_DIV=4, SETTLE_FRAMES=3, and a fast x/y raster model)
REQ-041 Reset, then start asserted when seed=5: ctrl steps 0,1,2 at 2-tick spacing, DECEL begins at tick 6, SETTLE is entered on the first MAX_DIV-period advance landing on 5, and done pulses once with result=5 three ticks later; busy covers exactly start+1 through done.
REQ-042 Wrap: seed=0 with sym_id passing 12 produces the sequence 12->0, with no id of 13 or above ever seen on ctrl.
REQ-043 stop_req at SPIN tick 2: DECEL entered on the next cycle; the SPIN_FRAMES expiry is never used.
REQ-044 start during SPIN and stop_req during DECEL or IDLE: no state, target or period change.
REQ-045 start and stop_req high together in IDLE: SPIN entered, with the full SPIN_FRAMES honoured.
REQ-046 reset_n low for 1 cycle in DECEL: the next cycle shows IDLE with ctrl=0, busy=0 and no done pulse; a subsequent start spins normally.
